ws2812_chain_driver: RTL

Parametrised WS2812B serial driver for LED chains of arbitrary length. On `start` it streams one frame of `NUM_LEDS` 24-bit pixels, fetched from a synchronous pixel RAM, as the single-wire 1/0 pulse code. It then holds the line low for the latch period and pulses `done`. It sits between the cube-face frame composer (which fills the pixel RAM) and the LED matrix pin, replacing fixed-length per-face streaming.

---
 rtl/ws2812_chain_driver.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ws2812_chain_driver.sv
// WS2812B chain driver: streams NUM_LEDS 24-bit pixels from a synchronous pixel RAM as 1/0 pulse code, then latches.
// Latency: start in cycle k -> busy in k+1, first dout rise in k+3, done at k+3+24*(THx+TLx)*NUM_LEDS+TRES.
// Backpressure: none; start is sampled only in IDLE and dropped while busy. The RAM is read with fixed 1-cycle latency.
//
// Ports: clk, reset (sync, active-high), start, pix_addr/pix_data (RAM read port),
//        bright (only when WS_BRIGHTNESS_EN is defined), dout (LED data pin), busy, done.
// Optional feature macro: WS_BRIGHTNESS_EN scales each colour byte by (bright+1)/256 when a pixel is loaded.
module ws2812_chain_driver #(
    parameter int NUM_LEDS = 64,
    parameter int T0H      = 16,
    parameter int T0L      = 34,
    parameter int T1H      = 32,
    parameter int T1L      = 18,
    parameter int TRES     = 2000,
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] pix_addr,
    input  logic [23:0]   pix_data,
`ifdef WS_BRIGHTNESS_EN
    input  logic [7:0]    bright,
`endif
    output logic          dout,
    output logic          busy,
    output logic          done
);

    localparam int MAX_A = (T0H > T0L) ? T0H : T0L;
    localparam int MAX_B = (T1H > T1L) ? T1H : T1L;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAXT  = (MAX_C > TRES) ? MAX_C : TRES;
    localparam int PW    = $clog2(MAXT + 1);

    // Phase counter counts down from duration-1 to 0.
    localparam logic [PW-1:0] T0H_M1  = PW'(T0H - 1);
    localparam logic [PW-1:0] T0L_M1  = PW'(T0L - 1);
    localparam logic [PW-1:0] T1H_M1  = PW'(T1H - 1);
    localparam logic [PW-1:0] T1L_M1  = PW'(T1L - 1);
    localparam logic [PW-1:0] TRES_M1 = PW'(TRES - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [4:0]      bit_q, bit_d;
    logic [AW-1:0]   led_q, led_d;
    logic [23:0]     sr_q, sr_d;
    logic            last_q, last_d;
    logic            dout_q, busy_q, done_q;
    logic            done_d;
    logic            load;
    logic [23:0]     pix_load;

`ifdef WS_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] b, input logic [8:0] k);
        logic [15:0] p;
        p = {8'b0, b} * {7'b0, k};
        return 8'(p >> 8);
    endfunction

    logic [8:0] bright_k;
    assign bright_k = {1'b0, bright} + 9'd1;
    assign pix_load = {scale(pix_data[23:16], bright_k),
                       scale(pix_data[15:8],  bright_k),
                       scale(pix_data[7:0],   bright_k)};
`else
    assign pix_load = pix_data;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        led_d   = led_q;
        sr_d    = sr_q;
        last_d  = last_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                led_d   = '0;
                phase_d = '0;
                bit_d   = '0;
                if (start) begin
                    state_d = FETCH;
                    phase_d = PW'(1);   // address cycle, then data cycle
                end
            end
            FETCH: begin
                if (phase_q != '0) phase_d = phase_q - 1'b1;
                else               load    = 1'b1;
            end
            HIGH: begin
                if (phase_q != '0) begin
                    phase_d = phase_q - 1'b1;
                end else begin
                    state_d = LOW;
                    phase_d = sr_q[23] ? T1L_M1 : T0L_M1;
                end
            end
            LOW: begin
                if (phase_q != '0) begin
                    phase_d = phase_q - 1'b1;
                end else if (bit_q != 5'd0) begin
                    sr_d    = sr_q << 1;
                    bit_d   = bit_q - 5'd1;
                    state_d = HIGH;
                    phase_d = sr_q[22] ? T1H_M1 : T0H_M1;
                end else if (!last_q) begin
                    load = 1'b1;        // next pixel already addressed, no gap
                end else begin
                    state_d = LATCH;
                    phase_d = TRES_M1;
                end
            end
            LATCH: begin
                if (phase_q != '0) begin
                    phase_d = phase_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    led_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pixel load: the address in led_q is the pixel being loaded. Advancing
        // led_q on the same edge makes it point at the next pixel from the first
        // HIGH cycle on. last_q remembers that the loaded pixel ends the frame.
        if (load) begin
            sr_d    = pix_load;
            bit_d   = 5'd23;
            state_d = HIGH;
            phase_d = pix_load[23] ? T1H_M1 : T0H_M1;
            last_d  = (led_q == LAST_ADDR);
            if (led_q != LAST_ADDR) led_d = led_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            led_q   <= '0;
            sr_q    <= '0;
            last_q  <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            led_q   <= led_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
            dout_q  <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign pix_addr = led_q;
    assign dout     = dout_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
